// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
// Takes the EX/MEM register and runs loads and stores over a
// single-outstanding req/ack data-memory port. Store data is lane-replicated
// with byte enables. Load data is extracted and sign- or zero-extended. The
// selected writeback value is registered into MEM/WB.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES stalled cycles without ack (the result is a bus error).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   *_mem                EX/MEM register fields (address/ALU value, store
//                        data, link PC, width, signedness, rd/wr request,
//                        writeback select, destination, write enable)
//   dmem_*               data-memory request/ack port
//   stall_mem            freezes EX/MEM while a transfer is pending
//   *_wb                 MEM/WB register outputs
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  input  logic [31:0] next_pc_mem,
  input  logic [1:0]  read_width_mem,
  input  logic        read_unsigned_mem,
  input  logic        rd_en_mem,
  input  logic        mem_wrt_en_mem,
  input  logic [1:0]  wb_sel_mem,
  input  logic [4:0]  wrt_dst_mem,
  input  logic        reg_wrt_en_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] wbdata_wb,
  output logic [4:0]  wrt_dst_wb,
  output logic        reg_wrt_en_wb,
  output logic        misalign_wb,
  output logic        bus_err_wb
);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntLog = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntLog > 8) ? CntLog : 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ABORT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_e;
`endif

  state_e      state_q;
  logic [31:0] wbdata_q;
  logic [4:0]  wrt_dst_q;
  logic        reg_wrt_en_q;
  logic        misalign_q;

  logic [1:0]  off_c;
  logic        pending_c;
  logic        bad_align_c;
  logic        misalign_c;
  logic        abort_c;
  logic [31:0] lane_c;
  logic [31:0] load_c;
  logic [31:0] wb_mux_c;

  assign off_c     = alu_result_mem[1:0];
  assign pending_c = rd_en_mem | mem_wrt_en_mem;
  // Shift the addressed lane down to bit 0 for sub-word extraction.
  assign lane_c    = dmem_rdata >> {off_c, 3'b000};

  // Width decode: byte enables, store replication, load extension, alignment.
  always_comb begin
    bad_align_c = 1'b0;
    dmem_be     = 4'b1111;
    dmem_wdata  = write_data_mem;
    load_c      = dmem_rdata;
    unique case (read_width_mem)
      2'b00: begin
        dmem_be    = 4'b0001 << off_c;
        dmem_wdata = {4{write_data_mem[7:0]}};
        load_c     = {{24{~read_unsigned_mem & lane_c[7]}}, lane_c[7:0]};
      end
      2'b01: begin
        bad_align_c = off_c[0];
        dmem_be     = 4'b0011 << off_c;
        dmem_wdata  = {2{write_data_mem[15:0]}};
        load_c      = {{16{~read_unsigned_mem & lane_c[15]}}, lane_c[15:0]};
      end
      default: begin
        bad_align_c = (off_c != 2'b00);
      end
    endcase
  end

  assign misalign_c = pending_c & bad_align_c;

`ifdef MEM_TIMEOUT_EN
  logic [CntW-1:0] wait_cnt_q;
  logic            bus_err_q;
  logic            timeout_c;

  assign abort_c = (state_q == S_ABORT);
  // The arrival cycle already stalled once, so abort after TIMEOUT_CYCLES
  // stalled cycles in total.
  assign timeout_c = (32'(wait_cnt_q) + 32'd2 >= 32'(TIMEOUT_CYCLES));
  assign bus_err_wb = bus_err_q;
`else
  logic unused_timeout;

  assign abort_c        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus_err_wb     = 1'b0;
`endif

  // Request path is combinational; EX/MEM is frozen while stalled.
  assign dmem_req  = pending_c & ~misalign_c & ~abort_c & rst_n;
  assign dmem_we   = mem_wrt_en_mem;
  assign dmem_addr = {alu_result_mem[31:2], 2'b00};
  assign stall_mem = dmem_req & ~dmem_ack;

  // Writeback source select; stores never return load data.
  always_comb begin
    wb_mux_c = alu_result_mem;
    unique case (wb_sel_mem)
      2'b01:   wb_mux_c = mem_wrt_en_mem ? 32'd0 : load_c;
      2'b10:   wb_mux_c = next_pc_mem;
      default: wb_mux_c = alu_result_mem;
    endcase
  end

  // Transfer FSM and MEM/WB register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wbdata_q     <= 32'd0;
      wrt_dst_q    <= 5'd0;
      reg_wrt_en_q <= 1'b0;
      misalign_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state_q <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state_q <= S_IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_c) begin
            state_q <= S_ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase

      if (stall_mem) begin
        // Bubble: data and destination hold, enables and flags clear.
        reg_wrt_en_q <= 1'b0;
        misalign_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_err_q    <= 1'b0;
`endif
      end else begin
        wbdata_q     <= wb_mux_c;
        wrt_dst_q    <= wrt_dst_mem;
        reg_wrt_en_q <= reg_wrt_en_mem & ~misalign_c & ~abort_c;
        misalign_q   <= misalign_c;
`ifdef MEM_TIMEOUT_EN
        bus_err_q    <= abort_c;
`endif
      end
    end
  end

  assign wbdata_wb     = wbdata_q;
  assign wrt_dst_wb    = wrt_dst_q;
  assign reg_wrt_en_wb = reg_wrt_en_q;
  assign misalign_wb   = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access.
// Each operation pushes its expected MEM/WB entry onto a scoreboard queue;
// the entry is popped and compared on the edge where the instruction leaves
// the stage. The memory side acks after a per-operation delay.
module tb_mem_access;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        we;
    logic        mis;
    logic        err;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result_mem, write_data_mem, next_pc_mem;
  logic [1:0]  read_width_mem, wb_sel_mem;
  logic        read_unsigned_mem, rd_en_mem, mem_wrt_en_mem, reg_wrt_en_mem;
  logic [4:0]  wrt_dst_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem;
  logic [31:0] wbdata_wb;
  logic [4:0]  wrt_dst_wb;
  logic        reg_wrt_en_wb, misalign_wb, bus_err_wb;

  int n_checks = 0;
  int n_errors = 0;
  wb_t sb_q[$];

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
    .next_pc_mem(next_pc_mem), .read_width_mem(read_width_mem),
    .read_unsigned_mem(read_unsigned_mem), .rd_en_mem(rd_en_mem),
    .mem_wrt_en_mem(mem_wrt_en_mem), .wb_sel_mem(wb_sel_mem),
    .wrt_dst_mem(wrt_dst_mem), .reg_wrt_en_mem(reg_wrt_en_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .wbdata_wb(wbdata_wb), .wrt_dst_wb(wrt_dst_wb),
    .reg_wrt_en_wb(reg_wrt_en_wb), .misalign_wb(misalign_wb),
    .bus_err_wb(bus_err_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input wb_t exp);
    chk({tag, ".data"}, wbdata_wb, exp.data);
    chk({tag, ".dst"}, 32'(wrt_dst_wb), 32'(exp.dst));
    chk({tag, ".we"}, 32'(reg_wrt_en_wb), 32'(exp.we));
    chk({tag, ".mis"}, 32'(misalign_wb), 32'(exp.mis));
    chk({tag, ".err"}, 32'(bus_err_wb), 32'(exp.err));
  endtask

  // Drive one instruction, then follow it until it leaves the stage.
  task automatic run_op(
    input string tag,
    input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] npc,
    input logic [31:0] rdata, input logic [1:0] width, input logic uns,
    input logic rd, input logic wr, input logic [1:0] sel, input logic [4:0] dst,
    input logic regwe, input int ack_dly,
    input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
    input int exp_stall, input wb_t exp_wb);
    wb_t got;
    @(negedge clk);
    alu_result_mem = addr; write_data_mem = wdat; next_pc_mem = npc;
    dmem_rdata = rdata; read_width_mem = width; read_unsigned_mem = uns;
    rd_en_mem = rd; mem_wrt_en_mem = wr; wb_sel_mem = sel;
    wrt_dst_mem = dst; reg_wrt_en_mem = regwe;
    sb_q.push_back(exp_wb);
    for (int c = 0; c <= exp_stall; c++) begin
      dmem_ack = (c >= ack_dly);
      #1;
      if (c == 0) begin
        chk({tag, ".req"}, 32'(dmem_req), 32'(exp_req));
        if (exp_req) begin
          chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
          chk({tag, ".be"}, 32'(dmem_be), 32'(exp_be));
          chk({tag, ".we_bus"}, 32'(dmem_we), 32'(wr));
          if (wr) chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
        end
      end
      chk({tag, ".stall"}, 32'(stall_mem), 32'(c < exp_stall));
      @(posedge clk);
      #1;
      if (c < exp_stall) begin
        chk({tag, ".bubble_we"}, 32'(reg_wrt_en_wb), 32'd0);
        @(negedge clk);
      end else begin
        got = sb_q.pop_front();
        chk_wb(tag, got);
      end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_result_mem = 32'd0; write_data_mem = 32'd0; next_pc_mem = 32'd0;
    read_width_mem = 2'b10; read_unsigned_mem = 1'b0;
    rd_en_mem = 1'b1; mem_wrt_en_mem = 1'b0; wb_sel_mem = 2'b00;
    wrt_dst_mem = 5'd9; reg_wrt_en_mem = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;

    // Reset with an access present: no request, no stall, MEM/WB clear.
    @(negedge clk); #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    chk_wb("rst", '{data: 32'd0, dst: 5'd0, we: 1'b0, mis: 1'b0, err: 1'b0});
    @(negedge clk);
    rd_en_mem = 1'b0;
    rst_n = 1'b1;

    //     tag   addr          wdat          npc    rdata         w     u     rd    wr    sel   dst    we   dly req  be       wdata         stl expected MEM/WB
    run_op("lb", 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 5'd5, 1'b1, 0, 1'b1, 4'b1000, 32'd0, 0,
           '{data: 32'hFFFF_FF80, dst: 5'd5, we: 1'b1, mis: 1'b0, err: 1'b0});
    run_op("sh", 32'h0000_2002, 32'h1234_ABCD, 32'd0, 32'd0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 3, 1'b1, 4'b1100, 32'hABCD_ABCD, 3,
           '{data: 32'h0000_2002, dst: 5'd0, we: 1'b0, mis: 1'b0, err: 1'b0});
    run_op("lw_mis", 32'h0000_3001, 32'd0, 32'd0, 32'h1111_1111, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 1'b1, 0, 1'b0, 4'b0000, 32'd0, 0,
           '{data: 32'h0000_3001, dst: 5'd7, we: 1'b0, mis: 1'b1, err: 1'b0});
    run_op("lhu", 32'h0000_4002, 32'd0, 32'd0, 32'hBEEF_0000, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 5'd3, 1'b1, 0, 1'b1, 4'b1100, 32'd0, 0,
           '{data: 32'h0000_BEEF, dst: 5'd3, we: 1'b1, mis: 1'b0, err: 1'b0});
    run_op("lw", 32'h0000_4004, 32'd0, 32'd0, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 5'd4, 1'b1, 0, 1'b1, 4'b1111, 32'd0, 0,
           '{data: 32'hCAFE_F00D, dst: 5'd4, we: 1'b1, mis: 1'b0, err: 1'b0});
    run_op("sb", 32'h0000_5001, 32'h0000_00A5, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 5'd2, 1'b0, 1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1,
           '{data: 32'h0000_0000, dst: 5'd2, we: 1'b0, mis: 1'b0, err: 1'b0});
    run_op("lh", 32'h0000_6000, 32'd0, 32'd0, 32'h1234_8001, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 5'd6, 1'b1, 2, 1'b1, 4'b0011, 32'd0, 2,
           '{data: 32'hFFFF_8001, dst: 5'd6, we: 1'b1, mis: 1'b0, err: 1'b0});
    run_op("st_win", 32'h0000_7000, 32'hDEAD_BEEF, 32'd0, 32'h5555_5555, 2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 5'd8, 1'b0, 0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0,
           '{data: 32'h0000_0000, dst: 5'd8, we: 1'b0, mis: 1'b0, err: 1'b0});
`ifdef MEM_TIMEOUT_EN
    run_op("tmo", 32'h0000_8000, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 5'd10, 1'b1, 1000, 1'b1, 4'b1111, 32'd0, 4,
           '{data: 32'h0000_8000, dst: 5'd10, we: 1'b0, mis: 1'b0, err: 1'b1});
`endif
    run_op("jal", 32'h1234_5678, 32'd0, 32'h0000_0104, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 5'd31, 1'b1, 0, 1'b0, 4'b0000, 32'd0, 0,
           '{data: 32'h0000_0104, dst: 5'd31, we: 1'b1, mis: 1'b0, err: 1'b0});

    // Reset while a load is waiting for ack.
    @(negedge clk);
    alu_result_mem = 32'h0000_9000; read_width_mem = 2'b10;
    rd_en_mem = 1'b1; mem_wrt_en_mem = 1'b0; wb_sel_mem = 2'b00;
    wrt_dst_mem = 5'd12; reg_wrt_en_mem = 1'b1; dmem_ack = 1'b0;
    #1;
    chk("rstw.stall0", 32'(stall_mem), 32'd1);
    @(negedge clk); #1;
    chk("rstw.stall1", 32'(stall_mem), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw.req", 32'(dmem_req), 32'd0);
    chk("rstw.stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    chk_wb("rstw", '{data: 32'd0, dst: 5'd0, we: 1'b0, mis: 1'b0, err: 1'b0});
    @(negedge clk);
    rd_en_mem = 1'b0;
    rst_n = 1'b1;

    // FSM must be back in IDLE: a zero-wait load completes normally.
    run_op("lb2", 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_0000, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 5'd5, 1'b1, 0, 1'b1, 4'b1000, 32'd0, 0,
           '{data: 32'h0000_0080, dst: 5'd5, we: 1'b1, mis: 1'b0, err: 1'b0});

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the processor pipeline. Consumes the EX/MEM pipeline register and performs loads and stores over a single-outstanding req/ack data-memory port. It aligns and byte-enables store data, and extracts and sign- or zero-extends load data. It drives `stall_mem` back to execute while a transfer is pending and registers the selected writeback value into the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait cycles before a pending transfer is aborted. Only used with the timeout macro.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `alu_result_mem` in 32: effective address, or the ALU writeback value.
- `write_data_mem` in 32: store data; the low bits are used for sub-word stores.
- `next_pc_mem` in 32: link value for jumps.
- `read_width_mem` in 2: access width for both loads and stores. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `read_unsigned_mem` in 1: 1 = zero-extend loads, 0 = sign-extend loads.
- `rd_en_mem` in 1: load request.
- `mem_wrt_en_mem` in 1: store request.
- `wb_sel_mem` in 2: writeback source. 00 = ALU, 01 = load data, 10 = next_pc, 11 = ALU.
- `wrt_dst_mem` in 5: destination register.
- `reg_wrt_en_mem` in 1: register write enable.
- `dmem_req` out 1: transfer request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word-aligned address, with [1:0] = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: transfer completes on any cycle where `dmem_req` and `dmem_ack` are both high.
- `dmem_rdata` in 32: load data, valid in the ack cycle.
- `stall_mem` out 1: freezes the EX/MEM register.
- `wbdata_wb` out 32: MEM/WB writeback value.
- `wrt_dst_wb` out 5: MEM/WB destination register.
- `reg_wrt_en_wb` out 1: MEM/WB register write enable.
- `misalign_wb` out 1: MEM/WB misaligned-access flag.
- `bus_err_wb` out 1: MEM/WB bus-timeout flag.

## Operation
- An access is pending when `rd_en_mem | mem_wrt_en_mem`. If both are set, the store wins.
- Offset `off` = `alu_result_mem[1:0]`.
- Byte access:
  - `be` = 0001 << off.
  - `wdata` = 4 copies of `write_data_mem[7:0]`.
  - Load data = `dmem_rdata[8*off +: 8]`, extended to 32 bits.
- Half access:
  - `off` must be 0 or 2.
  - `be` = 0011 << off.
  - `wdata` = 2 copies of `write_data_mem[15:0]`.
  - Load data = `dmem_rdata[8*off +: 16]`, extended to 32 bits.
- Word access: `off` must be 0; `be` = 1111.
- Misaligned access (half with odd `off`, word with `off` ≠ 0):
  - `dmem_req` is never asserted.
  - Completes in the same cycle with no stall.
  - MEM/WB gets `misalign_wb` = 1 and `reg_wrt_en_wb` = 0.
- Request signals are combinational from the inputs: `dmem_req` = aligned pending access & state ≠ ABORT & `rst_n`. Address, byte enables, write data and `dmem_we` stay stable while stalled, because the EX/MEM register is frozen.
- `stall_mem` = `dmem_req` & ~`dmem_ack`.
- FSM states:
  - IDLE → WAIT when `dmem_req` & ~`dmem_ack`.
  - WAIT → IDLE on `dmem_ack`.
  - WAIT → ABORT on timeout (timeout build only).
  - ABORT → IDLE after exactly one cycle.
- Back-to-back accesses: ack completes the current instruction. The next instruction arrives on the following edge and can request immediately; no idle cycle is required.
- MEM/WB register, when `stall_mem` = 0:
  - Captures `wbdata_wb` from the `wb_sel_mem` mux.
  - Captures `wrt_dst_wb`.
  - `reg_wrt_en_wb` = `reg_wrt_en_mem` & ~misaligned & ~abort.
  - Captures the error flags.
- MEM/WB register, when `stall_mem` = 1: captures a bubble, with `reg_wrt_en_wb` = 0, both flags = 0 and the data/destination held.
- Stores with `wb_sel_mem` = 01 write back 0.

## Timing
- Reset values:
  - All MEM/WB outputs are 0.
  - State is IDLE; counter is 0.
  - `dmem_req` and `stall_mem` are 0 during reset, even if an access is present.
- Zero-wait ack: the access completes in its arrival cycle; result appears in MEM/WB one edge later.
- k wait cycles: `stall_mem` is high for k cycles; the result is visible at edge k+1.
- Reset mid-transfer: the request drops in the reset cycle. The pending transfer is abandoned, and the memory side must tolerate this.
- Non-memory instructions never stall; they pass through with 1-cycle latency.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter counts cycles spent in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without ack, the FSM enters ABORT.
  - In ABORT: `dmem_req` = 0 and `stall_mem` = 0. The instruction completes with `bus_err_wb` = 1 and `reg_wrt_en_wb` = 0.
  - The counter clears on every transition into WAIT.
- `MEM_TIMEOUT_EN` undefined:
  - No counter and no ABORT state.
  - WAIT holds indefinitely.
  - `bus_err_wb` is tied to 0.

## Test plan
- Load byte, addr 0x1003, `rdata` 0x80FF_0000, signed, ack same cycle → `be`=1000, no stall, `wbdata_wb`=0xFFFF_FF80 one edge later.
- Store half, addr 0x2002, `write_data_mem` 0x1234_ABCD, ack after 3 cycles → `be`=1100, `wdata`=0xABCD_ABCD, `stall_mem` high exactly 3 cycles, 3 bubbles then `reg_wrt_en_wb`=0 on completion.
- Load word, addr 0x3001 → no `dmem_req`, no stall, `misalign_wb`=1, `reg_wrt_en_wb`=0.
- Back-to-back unsigned load half at 0x4002 (`rdata` 0xBEEF_0000), then load word at 0x4004, both zero-wait → `wbdata_wb` 0x0000_BEEF then the word value on consecutive edges, no stall.
- Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4), ack never given → stall for 4 cycles, ABORT, then `bus_err_wb`=1 and `reg_wrt_en_wb`=0.
- `rst_n` low during WAIT → `dmem_req` and `stall_mem` 0 in the reset cycle, all MEM/WB outputs 0, state IDLE.
